// File: rtl/npu_pkg.sv
// npu_pkg: sequencer state encoding, load-target codes and default end-of-pass addresses
package npu_pkg;
  typedef enum logic [3:0] {
    IDLE, C1_WREQ, C1_RUN, C1_DRAIN, C2_CLR, C2_WREQ, C2_RUN, FC_WREQ, FC_RUN, FIN, ERR
  } seq_state_e;
  localparam logic [1:0] WL_CONV1 = 2'd0;
  localparam logic [1:0] WL_CONV2 = 2'd1;
  localparam logic [1:0] WL_FC    = 2'd2;
  localparam int PIX1_LAST_DEF = 182;
  localparam int PIX2_LAST_DEF = 132;
endpackage

// File: rtl/npu_seq_wdog.sv
// npu_seq_wdog: timeout counter, cleared on request, counting while enabled
module npu_seq_wdog #(
  parameter int W   = 12,
  parameter int MAX = 4000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // expiry must not depend on clr: clr is derived from the next state, which depends on expiry
  assign expired = en && cnt_q == W'(MAX - 1);
endmodule

// File: rtl/npu_layer_seq.sv
// npu_layer_seq: sequences conv1 passes with drain, conv2 accumulation and the streamed FC layer,
// handshaking weight/image loads with the host and guarding every wait with a watchdog
module npu_layer_seq
  import npu_pkg::*;
#(
  parameter int CHAN_W    = 4,
  parameter int PIX1_LAST = PIX1_LAST_DEF,
  parameter int PIX2_LAST = PIX2_LAST_DEF,
  parameter int TMO_W     = 12,
  parameter int TMO_MAX   = 4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAN_W-1:0] cfg_chan,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [23:0]       result,
  output logic              wreq,
  output logic [1:0]        wreq_layer,
  output logic [7:0]        wreq_idx,
  input  logic              wack,
  output logic              drain_req,
  input  logic              drain_ack,
  output logic              conv_trigger,
  output logic              conv_clear,
  output logic              conv_layer,
  input  logic [7:0]        conv_addr,
  output logic              psum_clear,
  output logic              psum_ce,
  output logic              fc_start,
  output logic              fc_next,
  input  logic              fc_grp_req,
  input  logic              fc_done,
  input  logic [23:0]       fc_logit
);
  seq_state_e state_q, state_d;
  logic [CHAN_W-1:0] n_q, n_d, chan_q, chan_d, chan_inc;
  logic [7:0] grp_q, grp_d;
  logic [23:0] result_q, result_d;
  logic err_q, err_d, layer_q, layer_d, ce_q, ce_d;
  logic done_q, done_d, trig_q, trig_d, cclr_q, cclr_d, pclr_q, pclr_d, fcs_q, fcs_d, fcn_q, fcn_d;
  logic wd_en, wd_exp;
  assign chan_inc = chan_q + 1'b1;
  assign wd_en = !(state_q inside {IDLE, FIN, ERR});
  npu_seq_wdog #(.W(TMO_W), .MAX(TMO_MAX)) u_wdog (
    .clk(clk), .rst(rst), .clr(state_d != state_q), .en(wd_en), .expired(wd_exp)
  );
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    chan_d = chan_q;
    grp_d = grp_q;
    result_d = result_q;
    err_d = err_q;
    layer_d = layer_q;
    ce_d = ce_q;
    done_d = 1'b0;
    trig_d = 1'b0;
    cclr_d = 1'b0;
    pclr_d = 1'b0;
    fcs_d = 1'b0;
    fcn_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      ce_d = 1'b0;
      cclr_d = state_q inside {C1_RUN, C2_RUN};
    end else if (wd_exp) begin
      state_d = ERR;
      err_d = 1'b1;
      ce_d = 1'b0;
      layer_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ERR: if (start) begin
          state_d = C1_WREQ;
          n_d = cfg_chan == '0 ? CHAN_W'(1) : cfg_chan;
          chan_d = '0;
          grp_d = '0;
          err_d = 1'b0;
        end
        C1_WREQ: if (wack) begin
          state_d = C1_RUN;
          trig_d = 1'b1;
          layer_d = 1'b0;
        end
        C1_RUN: if (conv_addr == 8'(PIX1_LAST)) begin
          state_d = C1_DRAIN;
          cclr_d = 1'b1;
        end
        C1_DRAIN: if (drain_ack) begin
          state_d = chan_inc == n_q ? C2_CLR : C1_WREQ;
          chan_d = chan_inc == n_q ? '0 : chan_inc;
        end
        C2_CLR: begin
          state_d = C2_WREQ;
          pclr_d = 1'b1;
          layer_d = 1'b1;
          ce_d = 1'b1;
        end
        C2_WREQ: if (wack) begin
          state_d = C2_RUN;
          trig_d = 1'b1;
        end
        C2_RUN: if (conv_addr == 8'(PIX2_LAST)) begin
          state_d = chan_inc == n_q ? FC_WREQ : C2_WREQ;
          cclr_d = 1'b1;
          chan_d = chan_inc;
          ce_d = chan_inc != n_q;
        end
        FC_WREQ: if (wack) begin
          state_d = FC_RUN;
          fcs_d = grp_q == '0;
          fcn_d = grp_q != '0;
          grp_d = grp_q == 8'hFF ? grp_q : grp_q + 1'b1;
        end
        // fc_done outranks a simultaneous group request
        FC_RUN: if (fc_done) begin
          state_d = FIN;
          result_d = fc_logit;
          done_d = 1'b1;
        end else if (fc_grp_req) state_d = FC_WREQ;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      chan_q <= '0;
      grp_q <= '0;
      result_q <= '0;
      err_q <= 1'b0;
      layer_q <= 1'b0;
      ce_q <= 1'b0;
      done_q <= 1'b0;
      trig_q <= 1'b0;
      cclr_q <= 1'b0;
      pclr_q <= 1'b0;
      fcs_q <= 1'b0;
      fcn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      chan_q <= chan_d;
      grp_q <= grp_d;
      result_q <= result_d;
      err_q <= err_d;
      layer_q <= layer_d;
      ce_q <= ce_d;
      done_q <= done_d;
      trig_q <= trig_d;
      cclr_q <= cclr_d;
      pclr_q <= pclr_d;
      fcs_q <= fcs_d;
      fcn_q <= fcn_d;
    end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign result = result_q;
  assign wreq = state_q inside {C1_WREQ, C2_WREQ, FC_WREQ};
  assign wreq_layer = state_q == FC_WREQ ? WL_FC : state_q == C2_WREQ ? WL_CONV2 : WL_CONV1;
  assign wreq_idx = state_q == FC_WREQ ? grp_q : wreq ? 8'(chan_q) : '0;
  assign drain_req = state_q == C1_DRAIN;
  assign conv_trigger = trig_q;
  assign conv_clear = cclr_q;
  assign conv_layer = layer_q;
  assign psum_clear = pclr_q;
  assign psum_ce = ce_q;
  assign fc_start = fcs_q;
  assign fc_next = fcn_q;
endmodule

// File: tb/tb_npu_layer_seq.sv
// tb_npu_layer_seq: host/engine environment around npu_layer_seq, checked against the expected
// load order and event counts derived from the channel and FC group counts
module tb_npu_layer_seq;
  localparam int TMO_MAX = 4000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic wack = 1'b0, drain_ack = 1'b0, fc_grp_req = 1'b0, fc_done = 1'b0;
  logic [3:0] cfg_chan = '0;
  logic [7:0] conv_addr = '0;
  logic [23:0] fc_logit = '0;
  logic busy, done, err, wreq, drain_req, conv_trigger, conv_clear, conv_layer;
  logic psum_clear, psum_ce, fc_start, fc_next;
  logic [23:0] result;
  logic [1:0] wreq_layer;
  logic [7:0] wreq_idx;
  logic [45:0] all_out;
  int checks = 0, errors = 0;
  npu_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_chan(cfg_chan),
    .busy(busy), .done(done), .err(err), .result(result),
    .wreq(wreq), .wreq_layer(wreq_layer), .wreq_idx(wreq_idx), .wack(wack),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .conv_trigger(conv_trigger), .conv_clear(conv_clear), .conv_layer(conv_layer), .conv_addr(conv_addr),
    .psum_clear(psum_clear), .psum_ce(psum_ce),
    .fc_start(fc_start), .fc_next(fc_next), .fc_grp_req(fc_grp_req), .fc_done(fc_done), .fc_logit(fc_logit)
  );
  always #5 clk = ~clk;
  assign all_out = {busy, done, err, result, wreq, wreq_layer, wreq_idx, drain_req, conv_trigger,
                    conv_clear, conv_layer, psum_clear, psum_ce, fc_start, fc_next};
  // monitor: load requests in order, drain episodes, pulse-cycle counts
  // cnt: 0 drain, 1 conv_trigger, 2 conv_clear, 3 psum_clear, 4 fc_start, 5 fc_next, 6 done
  logic [9:0] wq[$];
  int cnt[7];
  logic wreq_p = 1'b0, drain_p = 1'b0;
  always @(negedge clk) begin
    if (wreq && !wreq_p) wq.push_back({wreq_layer, wreq_idx});
    if (drain_req && !drain_p) cnt[0]++;
    wreq_p = wreq;
    drain_p = drain_req;
    cnt[1] += int'(conv_trigger);
    cnt[2] += int'(conv_clear);
    cnt[3] += int'(psum_clear);
    cnt[4] += int'(fc_start);
    cnt[5] += int'(fc_next);
    cnt[6] += int'(done);
  end
  // environment: loader, conv engine, host drain and FC engine; stop_at 1 = C2 pass running, 2 = drain pending
  task automatic run_env(input int groups, input logic [23:0] logit, input int wdly, input bit noise,
                         input bit collide, input int stop_at, output bit ok, output int lat);
    int wc, dc, fcw, cl, served, cyc_fd;
    logic cly;
    wc = 0; dc = 0; fcw = -1; cl = -1; served = 0; cyc_fd = -1; cly = 1'b0; ok = 1'b0; lat = -1;
    conv_addr = '0;
    for (int cyc = 0; cyc < 3000 && !ok; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (noise && cyc == 8);
      wack = 1'b0; drain_ack = 1'b0; fc_grp_req = 1'b0; fc_done = 1'b0;
      if (done) begin
        ok = 1'b1;
        lat = cyc - cyc_fd;
      end else if ((stop_at == 1 && conv_trigger && conv_layer) || (stop_at == 2 && drain_req)) ok = 1'b1;
      else begin
        if (wreq) begin
          if (wc == wdly) begin wack = 1'b1; wc = 0; end else wc++;
        end else wc = 0;
        if (drain_req) begin
          if (dc == 2) begin drain_ack = 1'b1; dc = 0; end else dc++;
        end else dc = 0;
        if (conv_clear) conv_addr = '0;
        if (conv_trigger) begin
          cl = int'($urandom_range(2, 6)); cly = conv_layer; conv_addr = '0;
        end else if (cl > 0) begin
          cl--; conv_addr++;
        end else if (cl == 0) begin
          conv_addr = cly ? 8'd132 : 8'd182; cl = -1;
        end
        if (fc_start || fc_next) fcw = int'($urandom_range(1, 4));
        else if (fcw > 0) fcw--;
        else if (fcw == 0) begin
          fcw = -1;
          served++;
          if (served >= groups) begin
            fc_done = 1'b1; fc_logit = logit; fc_grp_req = collide; cyc_fd = cyc;
          end else fc_grp_req = 1'b1;
        end
      end
    end
    start = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_in outputs=%h expected 0", all_out); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_idle outputs=%h expected 0", all_out); end
  endtask
  task automatic test_inference;
    for (int it = 0; it < 6; it++) begin
      int n_cfg, n, g, wd, lat, wb;
      int b[7];
      logic [23:0] lg;
      logic [9:0] eq[$];
      logic [55:0] act_c, exp_c;
      bit ok, seq_ok;
      n_cfg = it == 0 ? 2 : it == 1 ? 0 : int'($urandom_range(0, 5));
      g = it == 0 ? 3 : it == 1 ? 1 : int'($urandom_range(1, 4));
      wd = it < 2 ? 3 : int'($urandom_range(1, 4));
      lg = it == 0 ? 24'hFFFFFB : 24'($urandom);
      n = n_cfg == 0 ? 1 : n_cfg;
      eq.delete();
      for (int l = 0; l < 2; l++) for (int c = 0; c < n; c++) eq.push_back({2'(l), 8'(c)});
      for (int k = 0; k < g; k++) eq.push_back({2'd2, 8'(k)});
      cfg_chan = 4'(n_cfg);
      b = cnt;
      wb = wq.size();
      run_env(g, lg, wd, it >= 2, 1'b0, 0, ok, lat);
      #1;
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL inf_timeout it=%0d done never seen", it); end
      seq_ok = (wq.size() - wb) == eq.size();
      for (int i = 0; i < eq.size() && seq_ok; i++) if (wq[wb + i] !== eq[i]) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin
        errors++;
        $display("FAIL inf_wreq_seq it=%0d got %0d loads expected %0d (n=%0d g=%0d)", it, wq.size() - wb, eq.size(), n, g);
      end
      act_c = {8'(cnt[0] - b[0]), 8'(cnt[1] - b[1]), 8'(cnt[2] - b[2]), 8'(cnt[3] - b[3]),
               8'(cnt[4] - b[4]), 8'(cnt[5] - b[5]), 8'(cnt[6] - b[6])};
      exp_c = {8'(n), 8'(2 * n), 8'(2 * n), 8'd1, 8'd1, 8'(g - 1), 8'd1};
      checks++;
      if (act_c !== exp_c) begin errors++; $display("FAIL inf_counts it=%0d got %h expected %h", it, act_c, exp_c); end
      checks++;
      if (result !== lg) begin errors++; $display("FAIL inf_result it=%0d got %h expected %h", it, result, lg); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL inf_done_lat it=%0d got %0d expected 1", it, lat); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== lg) begin
        errors++; $display("FAIL inf_after it=%0d busy=%b done=%b result=%h expected 0 0 %h", it, busy, done, result, lg);
      end
    end
  endtask
  task automatic test_collide;
    int wb, lat;
    bit ok;
    cfg_chan = 4'd1;
    wb = wq.size();
    run_env(1, 24'h012345, 2, 1'b0, 1'b1, 0, ok, lat);
    repeat (3) @(negedge clk);
    checks++;
    if (ok !== 1'b1 || lat !== 1) begin errors++; $display("FAIL collide_done ok=%b lat=%0d expected 1 1", ok, lat); end
    checks++;
    if (wq.size() - wb !== 3 || busy !== 1'b0) begin
      errors++; $display("FAIL collide_loads loads=%0d busy=%b expected 3 0", wq.size() - wb, busy);
    end
    checks++;
    if (result !== 24'h012345) begin errors++; $display("FAIL collide_result got %h expected 012345", result); end
  endtask
  task automatic test_abort;
    int b[7];
    int lat;
    bit ok;
    cfg_chan = 4'd2;
    b = cnt;
    run_env(2, 24'h000001, 1, 1'b0, 1'b0, 1, ok, lat);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL abort_reach C2 pass never started"); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if ({busy, conv_clear, psum_ce, done} !== 4'b0100) begin
      errors++; $display("FAIL abort_resp busy,conv_clear,psum_ce,done=%b expected 0100", {busy, conv_clear, psum_ce, done});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (cnt[6] - b[6] !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_nodone done_pulses=%0d busy=%b expected 0 0", cnt[6] - b[6], busy);
    end
    cfg_chan = 4'd1;
    b = cnt;
    run_env(2, 24'h7ABCDE, 2, 1'b0, 1'b0, 0, ok, lat);
    #1;
    checks++;
    if (ok !== 1'b1 || result !== 24'h7ABCDE || cnt[6] - b[6] !== 1 || cnt[3] - b[3] !== 1) begin
      errors++;
      $display("FAIL abort_rerun ok=%b result=%h done=%0d psum_clear=%0d expected 1 7abcde 1 1", ok, result, cnt[6] - b[6], cnt[3] - b[3]);
    end
  endtask
  task automatic test_watchdog;
    int lat;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      cfg_chan = 4'd1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (TMO_MAX - 3) @(negedge clk);
      checks++;
      if (err !== 1'b0 || wreq !== 1'b1) begin
        errors++; $display("FAIL wdog_early pass=%0d err=%b wreq=%b expected 0 1", pass, err, wreq);
      end
      repeat (5) @(negedge clk);
      checks++;
      if ({err, wreq, busy} !== 3'b101) begin
        errors++; $display("FAIL wdog_expire pass=%0d err,wreq,busy=%b expected 101", pass, {err, wreq, busy});
      end
      if (pass == 0) begin
        run_env(1, 24'h000777, 1, 1'b0, 1'b0, 0, ok, lat);
        #1;
        checks++;
        if (ok !== 1'b1 || err !== 1'b0 || result !== 24'h000777) begin
          errors++; $display("FAIL wdog_restart ok=%b err=%b result=%h expected 1 0 000777", ok, err, result);
        end
        @(negedge clk);
      end else begin
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if ({busy, err} !== 2'b01) begin
          errors++; $display("FAIL wdog_abort busy,err=%b expected 01", {busy, err});
        end
      end
    end
  endtask
  task automatic test_reset_drain;
    int lat;
    bit ok;
    cfg_chan = 4'd3;
    run_env(1, 24'h0, 1, 1'b0, 1'b0, 2, ok, lat);
    checks++;
    if (ok !== 1'b1 || drain_req !== 1'b1) begin errors++; $display("FAIL rstdrain_reach ok=%b drain_req=%b expected 1 1", ok, drain_req); end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstdrain_async outputs=%h expected 0", all_out); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); wack = 1'b1; drain_ack = 1'b1;
    @(negedge clk); wack = 1'b0; drain_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL rstdrain_stray outputs=%h expected 0", all_out); end
  endtask
  initial begin
    test_reset;
    test_inference;
    test_collide;
    test_abort;
    test_watchdog;
    test_reset_drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
